// File: rtl/motion_segment_queue_pkg.sv
// Shared types and constants for the motion segment queue.
// A descriptor is packed into one 130-bit FIFO word. Bit positions, LSB first:
//   dt [31:0], steps [63:32], a [95:64], j [127:96], set_a [128], set_j [129].
package motion_segment_queue_pkg;

   localparam int SEG_W       = 32;
   localparam int SEG_ENTRY_W = 4 * SEG_W + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // The field order is MSB first, so dt lands in the lowest 32 bits.
   typedef struct packed {
      logic                    set_j;
      logic                    set_a;
      logic signed [SEG_W-1:0] j;
      logic signed [SEG_W-1:0] a;
      logic        [SEG_W-1:0] steps;
      logic        [SEG_W-1:0] dt;
   } seg_entry_t;

   function automatic seg_entry_t seg_pack(
      input logic        [SEG_W-1:0] dt,
      input logic        [SEG_W-1:0] steps,
      input logic signed [SEG_W-1:0] a,
      input logic signed [SEG_W-1:0] j,
      input logic                    set_a,
      input logic                    set_j
   );
      seg_entry_t e;
      e.dt    = dt;
      e.steps = steps;
      e.a     = a;
      e.j     = j;
      e.set_a = set_a;
      e.set_j = set_j;
      return e;
   endfunction

endpackage

// File: rtl/motion_segment_queue_if.sv
// Host write port, downstream load port and status of the motion segment queue.
// The slave modport is the queue. The master modport is the host/downstream side.
interface motion_segment_queue_if #(
   parameter int ADDR_W = 4
);
   import motion_segment_queue_pkg::*;

   logic                    run;
   logic                    wr_stb;
   logic        [SEG_W-1:0] wr_dt;
   logic        [SEG_W-1:0] wr_steps;
   logic signed [SEG_W-1:0] wr_a;
   logic signed [SEG_W-1:0] wr_j;
   logic                    wr_set_a;
   logic                    wr_set_j;
   logic                    clr_flags;
   logic                    done;
   logic                    abort;

   logic                    load;
   logic        [SEG_W-1:0] dt_val;
   logic        [SEG_W-1:0] steps_val;
   logic signed [SEG_W-1:0] a_val;
   logic signed [SEG_W-1:0] j_val;
   logic                    set_a;
   logic                    set_j;
   logic       [ADDR_W:0]   level;
   logic                    full;
   logic                    busy;
   logic                    overflow;
   logic                    underrun;
   logic                    aborted;

   modport slave (
      input  run, wr_stb, wr_dt, wr_steps, wr_a, wr_j, wr_set_a, wr_set_j,
             clr_flags, done, abort,
      output load, dt_val, steps_val, a_val, j_val, set_a, set_j,
             level, full, busy, overflow, underrun, aborted
   );

   modport master (
      output run, wr_stb, wr_dt, wr_steps, wr_a, wr_j, wr_set_a, wr_set_j,
             clr_flags, done, abort,
      input  load, dt_val, steps_val, a_val, j_val, set_a, set_j,
             level, full, busy, overflow, underrun, aborted
   );

endinterface

// File: rtl/motion_segment_queue_seg_fifo.sv
// Synchronous descriptor FIFO. The read data is the head entry and is valid whenever level_o > 0.
// A push is accepted when the FIFO has space, or when a pop in the same cycle frees the head slot.
// A pop on an empty FIFO is ignored. A flush empties the FIFO in one cycle.
module seg_fifo #(
   parameter int ADDR_W = 4,
   parameter int W      = 130
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [W-1:0]    data_i,
   output logic [W-1:0]    data_o,
   output logic [ADDR_W:0] level_o,
   output logic            full_o
);

   localparam int               DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0]  FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

   logic [W-1:0]      mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              do_push, do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign level_o = level_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && (level_q != '0);
   assign do_push = push_i && (!full_o || do_pop);

   // Next pointers and fill level. The pointers wrap naturally modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer and level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array. It needs no reset because the level tracks which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/motion_segment_queue.sv
// Motion segment queue. It buffers host-written descriptors and issues them one at a time to the
// step and profile generators. An issued descriptor is marked by a single-cycle load pulse.
// The next descriptor is issued in the cycle after done, so back-to-back segments have no gap.
module motion_segment_queue
   import motion_segment_queue_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   motion_segment_queue_if.slave  q
);

   state_e                  state_q, state_d;
   logic                    load_q, load_d;
   logic                    set_a_q, set_a_d;
   logic                    set_j_q, set_j_d;
   logic        [SEG_W-1:0] dt_q, dt_d;
   logic        [SEG_W-1:0] steps_q, steps_d;
   logic signed [SEG_W-1:0] a_q, a_d;
   logic signed [SEG_W-1:0] j_q, j_d;
   logic                    overflow_q, overflow_d;
   logic                    underrun_q, underrun_d;
   logic                    aborted_q, aborted_d;

   logic                    fifo_push, fifo_pop, fifo_flush, fifo_full;
   logic       [ADDR_W:0]   fifo_level;
   seg_entry_t              fifo_wr, fifo_rd;
   logic                    level_nz;
   logic                    ev_overflow, ev_underrun, ev_abort;

   assign fifo_wr  = seg_pack(q.wr_dt, q.wr_steps, q.wr_a, q.wr_j, q.wr_set_a, q.wr_set_j);
   assign level_nz = (fifo_level != '0);

   seg_fifo #(
      .ADDR_W (ADDR_W),
      .W      (SEG_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (fifo_wr),
      .data_o  (fifo_rd),
      .level_o (fifo_level),
      .full_o  (fifo_full)
   );

   // Sequencing decisions. Abort overrides everything else and parks the queue in HALT.
   always_comb begin
      state_d     = state_q;
      fifo_pop    = 1'b0;
      fifo_flush  = 1'b0;
      ev_underrun = 1'b0;
      ev_abort    = 1'b0;
      if (q.abort) begin
         fifo_flush = 1'b1;
         ev_abort   = 1'b1;
         state_d    = ST_HALT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (q.run && level_nz && !aborted_q) begin
                  fifo_pop = 1'b1;
                  state_d  = ST_RUN;
               end
            end
            ST_RUN: begin
               if (q.done) begin
                  if (q.run && level_nz) begin
                     fifo_pop = 1'b1;
                  end else begin
                     state_d     = ST_IDLE;
                     ev_underrun = q.run;
                  end
               end
            end
            ST_HALT: begin
               if (q.clr_flags) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Host writes. Writes are dropped silently in HALT and during an abort.
   // A write into a full FIFO counts as overflow only when no pop frees a slot in the same cycle.
   always_comb begin
      fifo_push   = q.wr_stb && !q.abort && (state_q != ST_HALT);
      ev_overflow = fifo_push && fifo_full && !fifo_pop;
   end

   // Output and sticky-flag next state. When an event and clr_flags occur together, the event wins.
   always_comb begin
      load_d     = fifo_pop;
      set_a_d    = fifo_pop && fifo_rd.set_a;
      set_j_d    = fifo_pop && fifo_rd.set_j;
      dt_d       = fifo_pop ? fifo_rd.dt    : dt_q;
      steps_d    = fifo_pop ? fifo_rd.steps : steps_q;
      a_d        = fifo_pop ? fifo_rd.a     : a_q;
      j_d        = fifo_pop ? fifo_rd.j     : j_q;
      overflow_d = (overflow_q && !q.clr_flags) || ev_overflow;
      underrun_d = (underrun_q && !q.clr_flags) || ev_underrun;
      aborted_d  = (aborted_q  && !q.clr_flags) || ev_abort;
   end

   // State, output and flag registers. Reset clears all of them, including the held descriptor.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         load_q     <= 1'b0;
         set_a_q    <= 1'b0;
         set_j_q    <= 1'b0;
         dt_q       <= '0;
         steps_q    <= '0;
         a_q        <= '0;
         j_q        <= '0;
         overflow_q <= 1'b0;
         underrun_q <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         set_a_q    <= set_a_d;
         set_j_q    <= set_j_d;
         dt_q       <= dt_d;
         steps_q    <= steps_d;
         a_q        <= a_d;
         j_q        <= j_d;
         overflow_q <= overflow_d;
         underrun_q <= underrun_d;
         aborted_q  <= aborted_d;
      end
   end

   assign q.load      = load_q;
   assign q.set_a     = set_a_q;
   assign q.set_j     = set_j_q;
   assign q.dt_val    = dt_q;
   assign q.steps_val = steps_q;
   assign q.a_val     = a_q;
   assign q.j_val     = j_q;
   assign q.level     = fifo_level;
   assign q.full      = fifo_full;
   assign q.busy      = (state_q == ST_RUN);
   assign q.overflow  = overflow_q;
   assign q.underrun  = underrun_q;
   assign q.aborted   = aborted_q;

endmodule

// File: tb/tb_motion_segment_queue.sv
// Testbench for motion_segment_queue.
// Every accepted descriptor is pushed to a scoreboard. A negedge monitor pops the scoreboard
// on every load and compares the issued descriptor against the popped entry.
module tb_motion_segment_queue;
   import motion_segment_queue_pkg::*;

   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   motion_segment_queue_if #(.ADDR_W(ADDR_W)) qif();

   motion_segment_queue #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (qif.slave)
   );

   typedef struct {
      logic [31:0] dt;
      logic [31:0] steps;
      logic [31:0] a;
      logic [31:0] j;
      logic        sa;
      logic        sj;
   } exp_seg_t;

   exp_seg_t    sbq[$];
   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: each load must match the oldest outstanding accepted descriptor.
   always @(negedge clk) begin
      exp_seg_t e;
      if (!reset && qif.load) begin
         if (sbq.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_load: got load=1 dt_val=%0d, required no load", qif.dt_val);
         end else begin
            e = sbq.pop_front();
            chk("load.dt_val",    qif.dt_val,    e.dt);
            chk("load.steps_val", qif.steps_val, e.steps);
            chk("load.a_val",     qif.a_val,     e.a);
            chk("load.j_val",     qif.j_val,     e.j);
            chk("load.set_a",     qif.set_a,     e.sa);
            chk("load.set_j",     qif.set_j,     e.sj);
         end
      end else if (!reset && (qif.set_a || qif.set_j)) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL set_without_load: got set_a=%0d set_j=%0d, required 0", qif.set_a, qif.set_j);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      qif.run = 0; qif.wr_stb = 0; qif.wr_dt = 0; qif.wr_steps = 0; qif.wr_a = 0; qif.wr_j = 0;
      qif.wr_set_a = 0; qif.wr_set_j = 0; qif.clr_flags = 0; qif.done = 0; qif.abort = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
      sbq.delete();
   endtask

   task automatic set_wr(input logic [31:0] dt, input logic [31:0] st, input logic [31:0] a,
                         input logic [31:0] j, input logic sa, input logic sj);
      qif.wr_dt = dt; qif.wr_steps = st; qif.wr_a = a; qif.wr_j = j;
      qif.wr_set_a = sa; qif.wr_set_j = sj;
   endtask

   task automatic push(input logic [31:0] dt, input logic [31:0] st, input logic [31:0] a,
                       input logic [31:0] j, input logic sa, input logic sj, input bit accept);
      exp_seg_t e;
      set_wr(dt, st, a, j, sa, sj);
      qif.wr_stb = 1'b1;
      if (accept) begin
         e.dt = dt; e.steps = st; e.a = a; e.j = j; e.sa = sa; e.sj = sj;
         sbq.push_back(e);
      end
      step();
      qif.wr_stb = 1'b0;
   endtask

   task automatic pulse_done();
      qif.done = 1'b1;
      step();
      qif.done = 1'b0;
   endtask

   typedef struct {
      logic        run, wr_stb, sa, done, clr;
      logic [31:0] dt, steps, a;
      logic        exp_load, exp_busy, exp_underrun, exp_set_a;
      logic [31:0] exp_dt;
      logic [31:0] exp_level;
   } vec_t;

   vec_t tbl[5];

   initial begin
      exp_seg_t e;
      reset = 1'b1;
      clear_inputs();
      do_reset();

      // Reset state
      chk("rst.load", qif.load, 0);
      chk("rst.level", qif.level, 0);
      chk("rst.busy", qif.busy, 0);
      chk("rst.full", qif.full, 0);
      chk("rst.overflow", qif.overflow, 0);
      chk("rst.underrun", qif.underrun, 0);
      chk("rst.aborted", qif.aborted, 0);
      chk("rst.dt_val", qif.dt_val, 0);

      // Single segment: 2-edge latency, one-cycle set_a, underrun on done with empty queue, clr
      tbl[0] = '{run:1, wr_stb:1, sa:1, done:0, clr:0, dt:200, steps:3, a:200,
                 exp_load:0, exp_busy:0, exp_underrun:0, exp_set_a:0, exp_dt:0,   exp_level:1};
      tbl[1] = '{run:1, wr_stb:0, sa:0, done:0, clr:0, dt:0, steps:0, a:0,
                 exp_load:1, exp_busy:1, exp_underrun:0, exp_set_a:1, exp_dt:200, exp_level:0};
      tbl[2] = '{run:1, wr_stb:0, sa:0, done:0, clr:0, dt:0, steps:0, a:0,
                 exp_load:0, exp_busy:1, exp_underrun:0, exp_set_a:0, exp_dt:200, exp_level:0};
      tbl[3] = '{run:1, wr_stb:0, sa:0, done:1, clr:0, dt:0, steps:0, a:0,
                 exp_load:0, exp_busy:0, exp_underrun:1, exp_set_a:0, exp_dt:200, exp_level:0};
      tbl[4] = '{run:1, wr_stb:0, sa:0, done:0, clr:1, dt:0, steps:0, a:0,
                 exp_load:0, exp_busy:0, exp_underrun:0, exp_set_a:0, exp_dt:200, exp_level:0};
      for (int i = 0; i < 5; i++) begin
         qif.run = tbl[i].run; qif.wr_stb = tbl[i].wr_stb; qif.done = tbl[i].done;
         qif.clr_flags = tbl[i].clr;
         set_wr(tbl[i].dt, tbl[i].steps, tbl[i].a, 0, tbl[i].sa, 1'b0);
         if (tbl[i].wr_stb) begin
            e.dt = tbl[i].dt; e.steps = tbl[i].steps; e.a = tbl[i].a; e.j = 0;
            e.sa = tbl[i].sa; e.sj = 0;
            sbq.push_back(e);
         end
         step();
         chk($sformatf("t1[%0d].load", i),     qif.load,     tbl[i].exp_load);
         chk($sformatf("t1[%0d].busy", i),     qif.busy,     tbl[i].exp_busy);
         chk($sformatf("t1[%0d].underrun", i), qif.underrun, tbl[i].exp_underrun);
         chk($sformatf("t1[%0d].set_a", i),    qif.set_a,    tbl[i].exp_set_a);
         chk($sformatf("t1[%0d].dt_val", i),   qif.dt_val,   tbl[i].exp_dt);
         chk($sformatf("t1[%0d].level", i),    qif.level,    tbl[i].exp_level);
      end
      clear_inputs();

      // Three segments issued back to back, in FIFO order
      do_reset();
      push(11, 1, 32'hFFFF_FFF0, 5, 1, 0, 1);
      push(22, 2, 7, 32'hFFFF_FFFE, 0, 1, 1);
      push(33, 3, 9, 4, 1, 1, 1);
      chk("t2.level3", qif.level, 3);
      qif.run = 1;
      step();
      chk("t2.load1", qif.load, 1);
      chk("t2.level2", qif.level, 2);
      chk("t2.busy", qif.busy, 1);
      step();
      chk("t2.gap", qif.load, 0);
      pulse_done();
      chk("t2.load2", qif.load, 1);
      chk("t2.level1", qif.level, 1);
      step();
      pulse_done();
      chk("t2.load3", qif.load, 1);
      chk("t2.level0", qif.level, 0);
      step();
      chk("t2.hold_dt", qif.dt_val, 33);
      qif.run = 0;
      pulse_done();
      chk("t2.busy_end", qif.busy, 0);
      chk("t2.underrun", qif.underrun, 0);
      chk("t2.sb_drained", sbq.size(), 0);

      // Overflow at 17 writes, then a push and a pop in the same cycle at full, then drain
      do_reset();
      for (int i = 0; i < 17; i++) push(1000 + i, i, i, 0, 0, 0, (i < 16));
      chk("t3.full", qif.full, 1);
      chk("t3.level16", qif.level, 16);
      chk("t3.overflow", qif.overflow, 1);
      qif.clr_flags = 1;
      step();
      qif.clr_flags = 0;
      chk("t3.ovf_clr", qif.overflow, 0);
      qif.run = 1;
      push(2000, 77, 1, 2, 0, 1, 1);
      chk("t3.pp_load", qif.load, 1);
      chk("t3.pp_level", qif.level, 16);
      chk("t3.pp_overflow", qif.overflow, 0);
      for (int i = 0; i < 16; i++) begin
         pulse_done();
         chk($sformatf("t3.drain[%0d]", i), qif.load, 1);
         step();
      end
      qif.run = 0;
      pulse_done();
      chk("t3.level_end", qif.level, 0);
      chk("t3.busy_end", qif.busy, 0);
      chk("t3.sb_drained", sbq.size(), 0);

      // Abort while running with 5 queued, together with done and a write
      do_reset();
      for (int i = 0; i < 6; i++) push(500 + i, 1, 0, 0, 0, 0, 1);
      qif.run = 1;
      step();
      chk("t5.level5", qif.level, 5);
      step();
      qif.abort = 1; qif.done = 1; qif.wr_stb = 1;
      step();
      qif.abort = 0; qif.done = 0; qif.wr_stb = 0;
      sbq.delete();
      chk("t5.level0", qif.level, 0);
      chk("t5.aborted", qif.aborted, 1);
      chk("t5.busy", qif.busy, 0);
      chk("t5.noload", qif.load, 0);
      push(600, 1, 0, 0, 0, 0, 0);
      chk("t5.halt_level", qif.level, 0);
      chk("t5.halt_ovf", qif.overflow, 0);
      qif.clr_flags = 1;
      step();
      qif.clr_flags = 0;
      chk("t5.aborted_clr", qif.aborted, 0);
      push(700, 9, 3, 3, 1, 0, 1);
      chk("t5.lat1", qif.load, 0);
      step();
      chk("t5.lat2", qif.load, 1);
      chk("t5.dt", qif.dt_val, 700);

      // Reset while running with 4 queued
      do_reset();
      for (int i = 0; i < 5; i++) push(800 + i, 2, 0, 0, 1, 1, 1);
      qif.run = 1;
      step();
      chk("t6.level4", qif.level, 4);
      chk("t6.busy", qif.busy, 1);
      reset = 1;
      step();
      sbq.delete();
      chk("t6.load", qif.load, 0);
      chk("t6.level", qif.level, 0);
      chk("t6.busy0", qif.busy, 0);
      chk("t6.dt_val", qif.dt_val, 0);
      chk("t6.set_a", qif.set_a, 0);
      reset = 0;
      for (int i = 0; i < 4; i++) step();
      chk("t6.after_level", qif.level, 0);
      chk("t6.after_busy", qif.busy, 0);
      clear_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
